// File: rtl/aes_block_scheduler.sv
// Sequencer between the AHB register/FIFO side and the AES round core.
// Tracks key validity and mode, runs one block at a time from the input FIFO into the output buffer.
module aes_block_scheduler #(
    parameter int NUM_BLOCKS = 4,
    localparam int CNT_W = $clog2(NUM_BLOCKS + 1)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             enc_sel_i,
    input  logic             dec_sel_i,
    input  logic             key_load_i,
    input  logic [CNT_W-1:0] in_count_i,
    input  logic [127:0]     in_block_i,
    output logic             in_pop_o,
    output logic             core_key_start_o,
    input  logic             core_key_done_i,
    output logic             core_start_o,
    output logic             core_decrypt_o,
    output logic [127:0]     core_block_o,
    input  logic             core_done_i,
    input  logic [127:0]     core_result_i,
    output logic             out_wr_o,
    output logic [127:0]     out_block_o,
    input  logic             out_full_i,
    output logic             busy_o,
    output logic [2:0]       blocks_done_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] S_NO_KEY  = 3'd0;
    localparam logic [2:0] S_KEY_EXP = 3'd1;
    localparam logic [2:0] S_IDLE    = 3'd2;
    localparam logic [2:0] S_FETCH   = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_STORE   = 3'd5;

    // Handshakes: core/key start are one-cycle pulses on state entry; done pulses are only
    // accepted in the matching state; out_wr_o fires only while the buffer is not full.
    logic [2:0]   state_q, state_d;
    logic         first_q, first_d;
    logic         mode_q, mode_d;
    logic         pend_valid_q, pend_valid_d;
    logic         pend_mode_q, pend_mode_d;
    logic [127:0] core_block_q, core_block_d;
    logic [127:0] out_block_q, out_block_d;
    logic [2:0]   blocks_done_q, blocks_done_d;

    logic mode_pulse;
    logic in_flight;
    logic store_ok;

    always_comb begin
        state_d       = state_q;
        first_d       = 1'b0;
        mode_d        = mode_q;
        pend_valid_d  = pend_valid_q;
        pend_mode_d   = pend_mode_q;
        core_block_d  = core_block_q;
        out_block_d   = out_block_q;
        blocks_done_d = blocks_done_q;

        mode_pulse = enc_sel_i ^ dec_sel_i;
        in_flight  = (state_q == S_FETCH) || (state_q == S_RUN) || (state_q == S_STORE);
        store_ok   = (state_q == S_STORE) && !out_full_i && !key_load_i;

        case (state_q)
            S_NO_KEY: state_d = S_NO_KEY;
            S_KEY_EXP: begin
                if (core_key_done_i) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (in_count_i != '0) state_d = S_FETCH;
            end
            S_FETCH: begin
                core_block_d = in_block_i;
                first_d      = 1'b1;
                state_d      = S_RUN;
            end
            S_RUN: begin
                // The start cycle cannot carry a result for this block.
                if (!first_q && core_done_i) begin
                    out_block_d = core_result_i;
                    state_d     = S_STORE;
                end
            end
            S_STORE: begin
                if (store_ok) begin
                    blocks_done_d = blocks_done_q + 3'd1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_NO_KEY;
        endcase

        if (key_load_i) begin
            state_d       = S_KEY_EXP;
            first_d       = 1'b1;
            blocks_done_d = 3'd0;
            out_block_d   = out_block_q;
        end

        if (mode_pulse) begin
            if (in_flight) begin
                pend_valid_d = 1'b1;
                pend_mode_d  = dec_sel_i;
            end else begin
                mode_d       = dec_sel_i;
                pend_valid_d = 1'b0;
            end
        end

        // A deferred mode change lands as the in-flight block retires.
        if ((state_d == S_IDLE) && (state_q != S_IDLE) && pend_valid_d) begin
            mode_d       = pend_mode_d;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= S_NO_KEY;
            first_q       <= 1'b0;
            mode_q        <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_mode_q   <= 1'b0;
            core_block_q  <= '0;
            out_block_q   <= '0;
            blocks_done_q <= '0;
        end else begin
            state_q       <= state_d;
            first_q       <= first_d;
            mode_q        <= mode_d;
            pend_valid_q  <= pend_valid_d;
            pend_mode_q   <= pend_mode_d;
            core_block_q  <= core_block_d;
            out_block_q   <= out_block_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    assign in_pop_o         = (state_q == S_FETCH);
    assign core_key_start_o = (state_q == S_KEY_EXP) && first_q;
    assign core_start_o     = (state_q == S_RUN) && first_q;
    assign core_decrypt_o   = mode_q;
    assign core_block_o     = core_block_q;
    assign out_wr_o         = store_ok;
    assign out_block_o      = out_block_q;
    assign busy_o           = (state_q != S_NO_KEY) && (state_q != S_IDLE);
    assign blocks_done_o    = blocks_done_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Directed bench for aes_block_scheduler with a behavioural FIFO and AES core (result = block ^ key).
module tb_aes_block_scheduler;

  localparam int BLK_LAT = 12;
  localparam int KEY_LAT = 10;
  localparam logic [2:0] S_NO_KEY  = 3'd0;
  localparam logic [2:0] S_KEY_EXP = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_STORE   = 3'd5;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic enc_sel_i = 1'b0, dec_sel_i = 1'b0, key_load_i = 1'b0;
  logic [2:0] in_count_i;
  logic [127:0] in_block_i;
  logic in_pop_o, core_key_start_o, core_start_o, core_decrypt_o;
  logic core_key_done_i = 1'b0, core_done_i = 1'b0;
  logic [127:0] core_block_o, out_block_o;
  logic [127:0] core_result_i = '0;
  logic out_wr_o, busy_o;
  logic out_full_i = 1'b0;
  logic [2:0] blocks_done_o, state_o;

  // clock / reset
  always #5 HCLK = ~HCLK;

  aes_block_scheduler #(.NUM_BLOCKS(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .enc_sel_i(enc_sel_i), .dec_sel_i(dec_sel_i), .key_load_i(key_load_i),
    .in_count_i(in_count_i), .in_block_i(in_block_i), .in_pop_o(in_pop_o),
    .core_key_start_o(core_key_start_o), .core_key_done_i(core_key_done_i),
    .core_start_o(core_start_o), .core_decrypt_o(core_decrypt_o),
    .core_block_o(core_block_o), .core_done_i(core_done_i), .core_result_i(core_result_i),
    .out_wr_o(out_wr_o), .out_block_o(out_block_o), .out_full_i(out_full_i),
    .busy_o(busy_o), .blocks_done_o(blocks_done_o), .state_o(state_o)
  );

  logic [127:0] key_val = "ZXCVBNMASDFGHJKL";
  logic [127:0] blk_mem [0:15];
  int pushed = 0;
  int popped = 0;
  int cyc = 0;
  int pop_n = 0, start_n = 0, keystart_n = 0, wr_n = 0;
  int pop_cyc_q[$];
  int wr_cyc_q[$];
  logic mode_log[$];
  logic [127:0] exp_q[$];
  int tests_run = 0;
  int fails = 0;

  assign in_count_i = 3'(pushed - popped);
  assign in_block_i = blk_mem[popped[3:0]];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (in_pop_o) popped <= popped + 1;
  end

  // core model and output monitor
  int blk_cnt = 0, key_cnt = 0;
  logic [127:0] pend_res = '0;
  always @(negedge HCLK) begin
    core_done_i = 1'b0;
    core_key_done_i = 1'b0;
    if (blk_cnt > 0) begin
      blk_cnt--;
      if (blk_cnt == 0) begin
        core_done_i = 1'b1;
        core_result_i = pend_res;
      end
    end
    if (core_start_o) begin
      blk_cnt = BLK_LAT;
      pend_res = core_block_o ^ key_val;
      mode_log.push_back(core_decrypt_o);
      start_n++;
    end
    if (key_cnt > 0) begin
      key_cnt--;
      if (key_cnt == 0) core_key_done_i = 1'b1;
    end
    if (core_key_start_o) begin
      key_cnt = KEY_LAT;
      keystart_n++;
    end
    if (in_pop_o) begin
      pop_n++;
      pop_cyc_q.push_back(cyc);
    end
    if (out_wr_o) begin
      wr_n++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("wr_unexpected", 128'(out_wr_o), 128'(0));
      else check("wr_data", out_block_o, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && state_o != s; i++) step(1);
    check(tag, 128'(state_o), 128'(s));
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && wr_n < n; i++) step(1);
    check(tag, 128'(wr_n), 128'(n));
  endtask

  task automatic push_block(input logic [127:0] b, input logic expect_wr);
    blk_mem[pushed[3:0]] = b;
    if (expect_wr) exp_q.push_back(b ^ key_val);
    pushed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] b0, b1, b2, b3;
    int wr_before;
    b0 = "1234567890123456";
    b1 = "ABCDEFGHIJKLMNOP";
    b2 = "qwertyuiopasdfgh";
    b3 = "0123456789abcdef";
    for (int i = 0; i < 16; i++) blk_mem[i] = '0;

    // reset values
    step(3);
    check("rst_state", 128'(state_o), 128'(S_NO_KEY));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_pop", 128'(in_pop_o), 128'(0));
    check("rst_start", 128'(core_start_o), 128'(0));
    check("rst_key_start", 128'(core_key_start_o), 128'(0));
    check("rst_wr", 128'(out_wr_o), 128'(0));
    check("rst_mode", 128'(core_decrypt_o), 128'(0));
    check("rst_core_block", core_block_o, 128'(0));
    check("rst_out_block", out_block_o, 128'(0));
    check("rst_blocks_done", 128'(blocks_done_o), 128'(0));
    HRESETn = 1'b1;

    // data waiting but no key: nothing moves
    for (int i = 0; i < 4; i++) push_block(b0, 1'b1);
    step(50);
    check("nokey_pops", 128'(pop_n), 128'(0));
    check("nokey_starts", 128'(start_n), 128'(0));
    check("nokey_busy", 128'(busy_o), 128'(0));
    check("nokey_state", 128'(state_o), 128'(S_NO_KEY));

    // key load and expansion
    key_load_i = 1'b1;
    step(1);
    key_load_i = 1'b0;
    check("key_start_next", 128'(core_key_start_o), 128'(1));
    check("key_exp_state", 128'(state_o), 128'(S_KEY_EXP));
    check("key_exp_busy", 128'(busy_o), 128'(1));
    step(1);
    check("key_start_one_cycle", 128'(core_key_start_o), 128'(0));
    wait_state(S_IDLE, 30, "key_exp_to_idle");
    check("key_start_count", 128'(keystart_n), 128'(1));
    check("key_exp_no_pop", 128'(pop_n), 128'(0));
    step(1);
    check("pop_2_after_keydone", 128'(in_pop_o), 128'(1));

    // four blocks back to back
    wait_wr(4, 200, "four_writes");
    check("four_pops", 128'(pop_n), 128'(4));
    check("four_blocks_done", 128'(blocks_done_o), 128'(4));
    check("four_mode", 128'(core_decrypt_o), 128'(0));
    check("first_pop_to_wr", 128'(wr_cyc_q[0] - pop_cyc_q[0]), 128'(14));
    check("wr_to_next_pop", 128'(pop_cyc_q[1] - wr_cyc_q[0]), 128'(2));
    for (int i = 1; i < 4; i++) check("block_period", 128'(wr_cyc_q[i] - wr_cyc_q[i-1]), 128'(16));
    for (int i = 0; i < 4; i++) check("four_block_mode", 128'(mode_log[i]), 128'(0));
    check("four_idle", 128'(state_o), 128'(S_IDLE));
    check("four_not_busy", 128'(busy_o), 128'(0));

    // output backpressure
    out_full_i = 1'b1;
    push_block(b1, 1'b1);
    push_block(b2, 1'b1);
    wait_state(S_STORE, 60, "full_reach_store");
    for (int i = 0; i < 20; i++) begin
      check("full_no_wr", 128'(out_wr_o), 128'(0));
      check("full_block_stable", out_block_o, b1 ^ key_val);
      check("full_no_second_pop", 128'(pop_n), 128'(5));
      step(1);
    end
    out_full_i = 1'b0;
    #1;
    check("full_release_wr", 128'(out_wr_o), 128'(1));
    wait_wr(6, 100, "full_writes");
    check("full_blocks_done", 128'(blocks_done_o), 128'(6));
    check("full_pops", 128'(pop_n), 128'(6));

    // mode change while a block is in flight
    push_block(b2, 1'b1);
    push_block(b3, 1'b1);
    wait_state(S_RUN, 20, "mode_reach_run");
    step(2);
    dec_sel_i = 1'b1;
    step(1);
    dec_sel_i = 1'b0;
    check("mode_deferred", 128'(core_decrypt_o), 128'(0));
    wait_wr(8, 100, "mode_writes");
    check("mode_block1", 128'(mode_log[6]), 128'(0));
    check("mode_block2", 128'(mode_log[7]), 128'(1));
    check("mode_now_dec", 128'(core_decrypt_o), 128'(1));
    check("blocks_done_wrap", 128'(blocks_done_o), 128'(0));
    step(2);
    enc_sel_i = 1'b1;
    dec_sel_i = 1'b1;
    step(1);
    enc_sel_i = 1'b0;
    dec_sel_i = 1'b0;
    check("mode_both_ignored", 128'(core_decrypt_o), 128'(1));
    enc_sel_i = 1'b1;
    step(1);
    enc_sel_i = 1'b0;
    check("mode_enc_immediate", 128'(core_decrypt_o), 128'(0));

    // key reload aborts an in-flight block
    push_block(b1, 1'b0);
    wait_state(S_RUN, 20, "abort_reach_run");
    step(4);
    wr_before = wr_n;
    key_load_i = 1'b1;
    step(1);
    key_load_i = 1'b0;
    check("abort_key_start", 128'(core_key_start_o), 128'(1));
    check("abort_state", 128'(state_o), 128'(S_KEY_EXP));
    check("abort_blocks_done", 128'(blocks_done_o), 128'(0));
    push_block(b3, 1'b1);
    wait_state(S_IDLE, 40, "abort_to_idle");
    check("abort_no_wr", 128'(wr_n), 128'(wr_before));
    check("abort_no_refetch", 128'(pop_n), 128'(9));
    check("abort_key_starts", 128'(keystart_n), 128'(2));
    step(1);
    check("resume_pop", 128'(in_pop_o), 128'(1));
    wait_wr(wr_before + 1, 60, "resume_write");
    check("resume_blocks_done", 128'(blocks_done_o), 128'(1));
    check("resume_pops", 128'(pop_n), 128'(10));
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    // asynchronous reset mid-run
    push_block(b2, 1'b0);
    wait_state(S_RUN, 20, "rst2_reach_run");
    step(2);
    #2;
    HRESETn = 1'b0;
    #1;
    check("rst2_state", 128'(state_o), 128'(S_NO_KEY));
    check("rst2_busy", 128'(busy_o), 128'(0));
    check("rst2_core_block", core_block_o, 128'(0));
    check("rst2_out_block", out_block_o, 128'(0));
    check("rst2_blocks_done", 128'(blocks_done_o), 128'(0));
    step(2);
    HRESETn = 1'b1;
    wr_before = wr_n;
    step(20);
    check("rst2_no_wr", 128'(wr_n), 128'(wr_before));
    check("rst2_stays_nokey", 128'(state_o), 128'(S_NO_KEY));

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/aes_block_scheduler.md
# aes_block_scheduler

Sequences AES work between the AHB slave's register/FIFO side and the AES round core. It tracks key state and the encrypt/decrypt mode, and launches key expansion when a new key arrives. It pops 128-bit blocks from the input FIFO one at a time, runs each through the core, and writes each result into the output buffer, with backpressure. It sits inside the top-level wrapper, between the AHB slave decoder and the AES core.

## Interface
- NUM_BLOCKS, 4, depth of input FIFO and output buffer in 128-bit blocks; sets the width of in_count_i as $clog2(NUM_BLOCKS+1).
- HCLK  in  1  system clock, all logic on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- enc_sel_i  in  1  one-cycle pulse: select encrypt (register write to 0x04).
- dec_sel_i  in  1  one-cycle pulse: select decrypt (register write to 0x08).
- key_load_i  in  1  one-cycle pulse: last key word (0x1C) written, key register stable.
- in_count_i  in  3  full blocks available in input FIFO (0..4).
- in_block_i  in  128  head block of input FIFO, valid when in_count_i>0.
- in_pop_o  out  1  pop head block.
- core_key_start_o  out  1  one-cycle pulse: start key expansion.
- core_key_done_i  in  1  one-cycle pulse: key expansion complete.
- core_start_o  out  1  one-cycle pulse: start one block.
- core_decrypt_o  out  1  mode to core, 1=decrypt; registered level.
- core_block_o  out  128  registered block to core.
- core_done_i  in  1  one-cycle pulse: core_result_i valid.
- core_result_i  in  128  core output block.
- out_wr_o  out  1  write out_block_o to output buffer.
- out_block_o  out  128  registered result block.
- out_full_i  in  1  output buffer full.
- busy_o  out  1  state not NO_KEY/IDLE.
- blocks_done_o  out  3  results written since last key_load_i, wraps mod 8.

## Operation
- States: NO_KEY, KEY_EXP, IDLE, FETCH, RUN, STORE. Reset state is NO_KEY.
- NO_KEY: waits for key_load_i, then goes to KEY_EXP. in_count_i is ignored, so no data is processed without a key.
- KEY_EXP: core_key_start_o is high in the first cycle of the state only. Goes to IDLE on core_key_done_i.
- IDLE: if in_count_i>0, go to FETCH.
- FETCH: lasts one cycle. in_pop_o=1 and core_block_o<=in_block_i. Goes to RUN.
- RUN: core_start_o=1 in the first cycle only, and core_done_i is ignored in that cycle. On core_done_i: out_block_o<=core_result_i, go to STORE.
- STORE: out_wr_o = !out_full_i. When out_wr_o=1: blocks_done_o+=1, go to IDLE. Otherwise hold in STORE with out_block_o stable.
- Mode register reset value is 0 (encrypt).
- enc_sel_i/dec_sel_i apply immediately in NO_KEY/KEY_EXP/IDLE.
- In FETCH/RUN/STORE, a mode pulse is latched as pending and applied on the cycle of entry to IDLE, so the in-flight block keeps its mode.
- Both mode pulses in the same cycle: ignored, mode and pending unchanged. A later pulse overwrites an earlier pending one.
- key_load_i in any state: go to KEY_EXP next cycle and issue a fresh core_key_start_o; blocks_done_o<=0.
  - In-flight block is abandoned: no out_wr_o, and a popped block is not re-fetched.
  - A core_done_i arriving after the abort is ignored.
- key_load_i while in KEY_EXP restarts expansion with another start pulse.

## Timing
- Reset values: all outputs 0, core_block_o/out_block_o all-zero, mode encrypt, pending cleared.
- Cycle N: IDLE with in_count_i>0.
  - N+1: FETCH, in_pop_o=1.
  - N+2: RUN, core_start_o=1.
- core_done_i at cycle M → M+1 STORE, out_wr_o=1 if !out_full_i → M+2 IDLE.
- Per-block overhead beyond core latency: 4 cycles (IDLE, FETCH, start, STORE).
- Back-to-back: after STORE, IDLE re-evaluates in_count_i; the next pop happens 2 cycles after the write.
- key_load_i at cycle K: core_key_start_o at K+1. Earliest in_pop_o is 2 cycles after core_key_done_i.
- Reset asserted mid-operation: immediate return to NO_KEY, outputs to reset values, regardless of clock.

## Test plan
- Reset, then in_count_i=4 with no key → no in_pop_o and no core_start_o for 50 cycles; busy_o=0, state NO_KEY.
- key_load_i with key "ZXCVBNMASDFGHJKL"; core model returns core_key_done_i after 10 cycles → exactly one core_key_start_o; in_pop_o is 0 throughout key expansion.
- Four blocks "1234567890123456" queued; core model with 12-cycle latency, result = block XOR key → 4 pops, 4 out_wr_o each carrying the expected value, 16 cycles per block, blocks_done_o=4, core_decrypt_o=0.
- out_full_i held high for 20 cycles during the first STORE → out_wr_o=0 and out_block_o stable for those 20 cycles; write occurs in the first cycle after out_full_i falls; no second pop before that write.
- dec_sel_i pulse during RUN of block 1 → block 1 runs with core_decrypt_o=0; block 2 runs with core_decrypt_o=1. enc_sel_i and dec_sel_i in the same cycle → mode unchanged.
- key_load_i in the 5th RUN cycle → no out_wr_o for that block, core_key_start_o on the next cycle, blocks_done_o=0, late core_done_i ignored; processing resumes after core_key_done_i.
